// File: rtl/uart_host_bridge.sv
// uart_host_bridge
//   Autonomous bus master for the UART register block. It writes CTRL_INIT to
//   the control register once after reset. It then polls the status register.
//   Received bytes are moved from the rx data register to a byte stream, and
//   bytes from a second stream are pushed into the tx data register.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   tx_data_i/tx_valid_i/tx_ready_o   tx byte stream in (1-entry holding reg)
//   rx_data_o/rx_err_o/rx_valid_o/rx_ready_i  rx byte stream out (1-entry)
//   init_done_o                   control write has been issued
//   wr_en_cpu_o/rd_en_cpu_o       register write/read strobes
//   cpu_addr_o/cpu_data_o         register address / write data
//   cpu_data_i                    read data, valid the cycle after rd_en_cpu_o
module uart_host_bridge #(
    parameter int unsigned                CPU_ADDR_WIDTH = 2,
    parameter int unsigned                CPU_DATA_WIDTH = 32,
    parameter logic [CPU_DATA_WIDTH-1:0]  CTRL_INIT      = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [7:0]                tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic [7:0]                rx_data_o,
    output logic                      rx_err_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic                      init_done_o,
    output logic                      wr_en_cpu_o,
    output logic                      rd_en_cpu_o,
    output logic [CPU_ADDR_WIDTH-1:0] cpu_addr_o,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_o,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_i
);

    typedef enum logic [2:0] {
        INIT_WR,
        POLL_RD,
        POLL_WAIT,
        RX_RD,
        RX_WAIT,
        TX_WR
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_wr_en;
    logic                      w_rd_en;
    logic [CPU_ADDR_WIDTH-1:0] w_addr;
    logic [CPU_DATA_WIDTH-1:0] w_data;

    logic                      r_wr_en;
    logic                      r_rd_en;
    logic [CPU_ADDR_WIDTH-1:0] r_addr;
    logic [CPU_DATA_WIDTH-1:0] r_data;
    logic                      r_init_done;
    logic [5:0]                r_status_q;
    logic                      r_tx_ready;
    logic [7:0]                r_tx_byte;
    logic                      r_rx_valid;
    logic [7:0]                r_rx_data;
    logic                      r_rx_err;
    logic                      w_unused;

    // Only a few status/read-data bits are consumed.
    assign w_unused = &{1'b0, cpu_data_i, r_status_q[5], r_status_q[2:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= INIT_WR;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are registered from the next state so that they are visible
    // during the cycle the FSM spends in the matching state. INIT_WR is held
    // one extra cycle after reset so that the reset cycle keeps the strobes low.
    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        case (r_state)
            INIT_WR:   w_next = r_wr_en ? POLL_RD : INIT_WR;
            POLL_RD:   w_next = POLL_WAIT;
            POLL_WAIT: begin
                if (cpu_data_i[2] && !r_rx_valid) begin
                    w_next = RX_RD;
                end else if (!r_tx_ready && !cpu_data_i[0]) begin
                    w_next = TX_WR;
                end else begin
                    w_next = POLL_RD;
                end
            end
            RX_RD:     w_next = RX_WAIT;
            RX_WAIT:   w_next = POLL_RD;
            TX_WR:     w_next = POLL_RD;
            default:   w_next = INIT_WR;
        endcase
        case (w_next)
            INIT_WR: begin
                w_wr_en = 1'b1;
                w_data  = CTRL_INIT;
            end
            POLL_RD: begin
                w_rd_en = 1'b1;
                w_addr  = CPU_ADDR_WIDTH'(1);
            end
            RX_RD: begin
                w_rd_en = 1'b1;
                w_addr  = CPU_ADDR_WIDTH'(3);
            end
            TX_WR: begin
                w_wr_en      = 1'b1;
                w_addr       = CPU_ADDR_WIDTH'(2);
                w_data[8]    = 1'b1;
                w_data[7:0]  = r_tx_byte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_init_done <= 1'b0;
            r_status_q  <= '0;
        end else begin
            r_wr_en <= w_wr_en;
            r_rd_en <= w_rd_en;
            r_addr  <= w_addr;
            r_data  <= w_data;
            if (r_state == INIT_WR && w_next == POLL_RD) begin
                r_init_done <= 1'b1;
            end
            if (r_state == POLL_WAIT) begin
                r_status_q <= cpu_data_i[5:0];
            end
        end
    end

    // Tx holding register: frees in the TX_WR cycle, so a byte offered in
    // that same cycle still sees tx_ready_o low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_ready <= 1'b1;
            r_tx_byte  <= '0;
        end else if (r_state == TX_WR) begin
            r_tx_ready <= 1'b1;
        end else if (tx_valid_i && r_tx_ready) begin
            r_tx_ready <= 1'b0;
            r_tx_byte  <= tx_data_i;
        end
    end

    // Rx holding register: RX_WAIT is only entered while empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_err   <= 1'b0;
        end else if (r_state == RX_WAIT) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= cpu_data_i[7:0];
            r_rx_err   <= r_status_q[3] | r_status_q[4];
        end else if (r_rx_valid && rx_ready_i) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign wr_en_cpu_o = r_wr_en;
    assign rd_en_cpu_o = r_rd_en;
    assign cpu_addr_o  = r_addr;
    assign cpu_data_o  = r_data;
    assign init_done_o = r_init_done;
    assign tx_ready_o  = r_tx_ready;
    assign rx_valid_o  = r_rx_valid;
    assign rx_data_o   = r_rx_data;
    assign rx_err_o    = r_rx_err;

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge
//   Drives uart_host_bridge against a behavioural UART register block
//   (status/rx-data registers with one-cycle read latency) and compares the
//   bridge's bus activity and byte streams to hand-computed values.
module tb_uart_host_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_err_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        init_done_o;
    logic        wr_en_cpu_o;
    logic        rd_en_cpu_o;
    logic [1:0]  cpu_addr_o;
    logic [31:0] cpu_data_o;
    logic [31:0] cpu_data_i;

    always #5 clk = ~clk;

    uart_host_bridge #(
        .CPU_ADDR_WIDTH (2),
        .CPU_DATA_WIDTH (32),
        .CTRL_INIT      (32'h15)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .rx_data_o   (rx_data_o),
        .rx_err_o    (rx_err_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .init_done_o (init_done_o),
        .wr_en_cpu_o (wr_en_cpu_o),
        .rd_en_cpu_o (rd_en_cpu_o),
        .cpu_addr_o  (cpu_addr_o),
        .cpu_data_o  (cpu_data_o),
        .cpu_data_i  (cpu_data_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register block model state
    logic [31:0] st_base   = '0;
    logic        rx_flag   = 1'b0;
    logic        rx_sticky = 1'b0;
    logic [7:0]  rx_byte   = '0;
    int          busy_polls = 0;
    logic [31:0] pend      = '0;
    logic        pend_v    = 1'b0;

    // Bus activity log
    int          cyc = 0;
    int          n_wr0 = 0, n_wr2 = 0, n_rd1 = 0, n_rd3 = 0;
    logic [31:0] last_wr0 = '0, last_wr2 = '0;
    int          cyc_rd3 = 0, cyc_wr2 = 0, rx_stat_cyc = 0;

    typedef struct {
        logic [31:0] status;
        logic [7:0]  rx_val;
        logic [7:0]  exp_data;
        logic        exp_err;
    } rx_vec_t;

    rx_vec_t vecs [5];

    // Read data appears the cycle after the read strobe.
    initial begin
        cpu_data_i = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1 cpu_data_i = pend_v ? pend : '0;
        end
    end

    initial begin
        logic [31:0] resp;
        logic        bad;
        forever begin
            @(negedge clk);
            bad = (wr_en_cpu_o && rd_en_cpu_o) ||
                  (!wr_en_cpu_o && !rd_en_cpu_o && (cpu_addr_o != 2'd0 || cpu_data_o != 32'd0));
            chk("bus_protocol", {31'd0, bad}, 32'd0);
            resp = '0;
            if (rd_en_cpu_o) begin
                if (cpu_addr_o == 2'd1) begin
                    resp = st_base | (rx_flag ? 32'h4 : 32'h0) | (busy_polls > 0 ? 32'h1 : 32'h0);
                    if (busy_polls > 0) busy_polls--;
                    n_rd1++;
                    if (rx_flag) rx_stat_cyc = cyc;
                end else if (cpu_addr_o == 2'd3) begin
                    resp = {24'h0, rx_byte};
                    n_rd3++;
                    cyc_rd3 = cyc;
                    if (!rx_sticky) rx_flag = 1'b0;
                end
                pend   = resp;
                pend_v = 1'b1;
            end else begin
                pend_v = 1'b0;
            end
            if (wr_en_cpu_o) begin
                if (cpu_addr_o == 2'd0) begin
                    n_wr0++;
                    last_wr0 = cpu_data_o;
                end else if (cpu_addr_o == 2'd2) begin
                    n_wr2++;
                    last_wr2 = cpu_data_o;
                    cyc_wr2  = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_rx_valid();
        for (int k = 0; k < 40 && !rx_valid_o; k++) @(negedge clk);
        chk("rx_valid_timeout", {31'd0, rx_valid_o}, 32'd1);
    endtask

    task automatic wait_wr2();
        for (int k = 0; k < 60 && !(wr_en_cpu_o && cpu_addr_o == 2'd2); k++) @(negedge clk);
        chk("wr2_timeout", {31'd0, wr_en_cpu_o && cpu_addr_o == 2'd2}, 32'd1);
    endtask

    initial begin
        int n2, n3, r1, a;
        vecs[0] = '{32'h04, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{32'h1C, 8'h5A, 8'h5A, 1'b1};
        vecs[2] = '{32'h0C, 8'h3C, 8'h3C, 1'b1};
        vecs[3] = '{32'h14, 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{32'h24, 8'h00, 8'h00, 1'b0};

        rst = 1'b1; tx_data_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en_cpu_o}, 0);
        chk("rst_rd_en", {31'd0, rd_en_cpu_o}, 0);
        chk("rst_tx_ready", {31'd0, tx_ready_o}, 1);
        chk("rst_rx_valid", {31'd0, rx_valid_o}, 0);
        chk("rst_rx_data", {24'd0, rx_data_o}, 0);
        chk("rst_rx_err", {31'd0, rx_err_o}, 0);
        chk("rst_init_done", {31'd0, init_done_o}, 0);
        rst = 1'b0;

        // Init write, then status polling every 2 cycles
        @(posedge clk); #1;
        chk("init_wr_en", {31'd0, wr_en_cpu_o}, 1);
        chk("init_addr", {30'd0, cpu_addr_o}, 0);
        chk("init_data", cpu_data_o, 32'h15);
        chk("init_done_early", {31'd0, init_done_o}, 0);
        @(posedge clk); #1;
        chk("init_done", {31'd0, init_done_o}, 1);
        chk("poll1_rd", {31'd0, rd_en_cpu_o}, 1);
        chk("poll1_addr", {30'd0, cpu_addr_o}, 1);
        @(posedge clk); #1;
        chk("poll_gap_rd", {31'd0, rd_en_cpu_o}, 0);
        @(posedge clk); #1;
        chk("poll2_rd", {31'd0, rd_en_cpu_o}, 1);
        chk("poll2_addr", {30'd0, cpu_addr_o}, 1);
        repeat (6) @(negedge clk);
        chk("init_wr_count", n_wr0, 1);
        chk("init_wr_data", last_wr0, 32'h15);

        // Table-driven rx vectors
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            st_base = vecs[i].status & ~32'h4;
            rx_byte = vecs[i].rx_val;
            rx_flag = vecs[i].status[2];
            wait_rx_valid();
            chk("rx_data", {24'd0, rx_data_o}, {24'd0, vecs[i].exp_data});
            chk("rx_err", {31'd0, rx_err_o}, {31'd0, vecs[i].exp_err});
            chk("rx_latency", cyc - rx_stat_cyc, 4);
            chk("rd3_latency", cyc_rd3 - rx_stat_cyc, 2);
            @(negedge clk);
            chk("rx_pulse", {31'd0, rx_valid_o}, 0);
            st_base = '0;
            repeat (3) @(negedge clk);
        end

        // Consumer stalled: exactly one rx data read while full
        @(negedge clk);
        rx_ready_i = 1'b0; rx_sticky = 1'b1; rx_byte = 8'h77; n3 = n_rd3; rx_flag = 1'b1;
        repeat (30) @(negedge clk);
        chk("hold_rd3_count", n_rd3 - n3, 1);
        chk("hold_rx_valid", {31'd0, rx_valid_o}, 1);
        chk("hold_rx_data", {24'd0, rx_data_o}, 32'h77);
        rx_ready_i = 1'b1;
        @(negedge clk);
        chk("hold_release", {31'd0, rx_valid_o}, 0);
        rx_flag = 1'b0; rx_sticky = 1'b0;
        repeat (10) @(negedge clk);

        // Tx while busy for 3 polls
        n2 = n_wr2;
        @(posedge clk); #1;
        chk("tx_ready_idle", {31'd0, tx_ready_o}, 1);
        busy_polls = 3; r1 = n_rd1; tx_data_i = 8'h3C; tx_valid_i = 1'b1;
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
        chk("tx_ready_full", {31'd0, tx_ready_o}, 0);
        wait_wr2();
        chk("tx_wr_data", cpu_data_o, 32'h13C);
        chk("tx_after_busy", {31'd0, (busy_polls == 0) && (n_rd1 - r1 >= 4)}, 1);
        chk("tx_ready_in_wr", {31'd0, tx_ready_o}, 0);
        tx_data_i = 8'h55; tx_valid_i = 1'b1;
        @(negedge clk);
        chk("tx_ready_back", {31'd0, tx_ready_o}, 1);
        tx_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("tx_single_wr", n_wr2 - n2, 1);

        // Tx latency with tx idle
        @(posedge clk); #1;
        tx_data_i = 8'h81; tx_valid_i = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        tx_valid_i = 1'b0;
        wait_wr2();
        chk("tx_lat_data", cpu_data_o, 32'h181);
        chk("tx_latency_le2", {31'd0, (cyc - a) <= 2}, 1);
        repeat (6) @(negedge clk);

        // Rx has priority over a pending tx byte
        @(posedge clk); #1;
        st_base = 32'h1; tx_data_i = 8'h42; tx_valid_i = 1'b1;
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        n2 = n_wr2; n3 = n_rd3;
        st_base = '0; rx_byte = 8'h99; rx_flag = 1'b1;
        repeat (20) @(negedge clk);
        chk("prio_rd3_count", n_rd3 - n3, 1);
        chk("prio_wr2_count", n_wr2 - n2, 1);
        chk("prio_order_gap", cyc_wr2 - cyc_rd3, 4);
        chk("prio_wr_data", last_wr2, 32'h142);

        // Reset during RX_WAIT with a tx byte pending
        @(posedge clk); #1;
        st_base = 32'h1; tx_data_i = 8'h66; tx_valid_i = 1'b1;
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
        @(negedge clk);
        rx_byte = 8'h11; rx_flag = 1'b1;
        for (int k = 0; k < 40 && !(rd_en_cpu_o && cpu_addr_o == 2'd3); k++) @(negedge clk);
        chk("rst_rd3_seen", {31'd0, rd_en_cpu_o && cpu_addr_o == 2'd3}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_ready", {31'd0, tx_ready_o}, 1);
        chk("mid_rst_init_done", {31'd0, init_done_o}, 0);
        @(posedge clk); #1;
        chk("mid_rst_rx_valid", {31'd0, rx_valid_o}, 0);
        chk("mid_rst_strobes", {30'd0, wr_en_cpu_o, rd_en_cpu_o}, 0);
        st_base = '0; rx_flag = 1'b0;
        @(negedge clk);
        n3 = n_wr0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("restart_wr_en", {31'd0, wr_en_cpu_o}, 1);
        chk("restart_addr", {30'd0, cpu_addr_o}, 0);
        chk("restart_data", cpu_data_o, 32'h15);
        repeat (5) @(negedge clk);
        chk("restart_wr0_count", n_wr0 - n3, 1);
        chk("restart_init_done", {31'd0, init_done_o}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
